lwc_arx_pe: RTL

Pipelined, parametrised add-rotate-xor processing element for the lightweight-crypto datapath. Each operand is rotated left by an arbitrary amount, then combined by a small ALU. The ALU output can be XOR-ed with, and/or stored into, one of several accumulator slots. A two-stage pipeline with valid/ready handshakes on both sides moves transactions through, so the PE sits directly between the operand fetch logic and the round-state writeback.

---
 rtl/lwc_arx_pe_if.sv | 44 ++++
 rtl/lwc_arx_pe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lwc_arx_pe_if.sv
// Handshake/data bundle for lwc_arx_pe: operand side (in_*) and result side (out_*).
// The rotr field exists only when LWC_ARX_PE_POSTROT_EN is defined.
interface lwc_arx_pe_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_DEPTH = 4
);
  localparam int ROT_W = $clog2(WIDTH);
  localparam int SEL_W = $clog2(ACC_DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [ROT_W-1:0] rota;
  logic [ROT_W-1:0] rotb;
  logic [2:0]       op;
  logic [SEL_W-1:0] acc_sel;
  logic [1:0]       acc_mode;
  logic             acc_clr;
  logic             flush;
`ifdef LWC_ARX_PE_POSTROT_EN
  logic [ROT_W-1:0] rotr;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;

  modport slave (
`ifdef LWC_ARX_PE_POSTROT_EN
    input  rotr,
`endif
    input  in_valid, opa, opb, rota, rotb, op, acc_sel, acc_mode, acc_clr, flush, out_ready,
    output in_ready, out_valid, result, carry
  );

  modport master (
`ifdef LWC_ARX_PE_POSTROT_EN
    output rotr,
`endif
    output in_valid, opa, opb, rota, rotb, op, acc_sel, acc_mode, acc_clr, flush, out_ready,
    input  in_ready, out_valid, result, carry
  );
endinterface

// File: rtl/lwc_arx_pe.sv
// Two-stage add-rotate-xor PE with accumulator slots and valid/ready on both sides.
// Optional output rotate stage enabled by defining LWC_ARX_PE_POSTROT_EN.
module lwc_arx_pe #(
  parameter int WIDTH     = 32,
  parameter int ACC_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  lwc_arx_pe_if.slave  bus
);
  localparam int ROT_W = $clog2(WIDTH);
  localparam int SEL_W = $clog2(ACC_DEPTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       op;
    logic [SEL_W-1:0] sel;
    logic [1:0]       mode;
`ifdef LWC_ARX_PE_POSTROT_EN
    logic [ROT_W-1:0] rotr;
`endif
  } s1_t;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic [ROT_W-1:0] n);
    logic [2*WIDTH-1:0] t;
    t = {x, x} << n;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  logic [2:1]                       vld_q;
  s1_t                              s1_q, s1_d;
  logic [ACC_DEPTH-1:0][WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]                 result_q, result_d;
  logic                             carry_q;
  logic [WIDTH-1:0]                 alu_r, o;
  logic                             alu_c;
  logic                             s1_en, s2_en, s1_load, s2_load;

  assign s2_en        = !vld_q[2] | bus.out_ready;
  assign s1_en        = !vld_q[1] | s2_en;
  assign bus.in_ready = s1_en;
  assign s1_load      = bus.in_valid & s1_en;
  // A flush cancels the S2 load in the same cycle, so flushed work never touches the slots.
  assign s2_load      = vld_q[1] & s2_en & !bus.flush;

  always_comb begin
    s1_d      = '0;
    s1_d.ra   = rotl(bus.opa, bus.rota);
    s1_d.rb   = rotl(bus.opb, bus.rotb);
    s1_d.op   = bus.op;
    s1_d.sel  = bus.acc_sel;
    s1_d.mode = bus.acc_mode;
`ifdef LWC_ARX_PE_POSTROT_EN
    s1_d.rotr = bus.rotr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (bus.flush) begin
      vld_q <= '0;
    end else begin
      if (s1_en) vld_q[1] <= bus.in_valid;
      if (s2_en) vld_q[2] <= vld_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          s1_q <= '0;
    else if (s1_load) s1_q <= s1_d;
  end

  // ADD/SUB carry out of the extra MSB; SUB yields not-borrow via a + ~b + 1.
  always_comb begin
    alu_c = 1'b0;
    alu_r = s1_q.ra;
    case (s1_q.op)
      OP_ADD:  {alu_c, alu_r} = {1'b0, s1_q.ra} + {1'b0, s1_q.rb};
      OP_SUB:  {alu_c, alu_r} = {1'b0, s1_q.ra} + {1'b0, ~s1_q.rb} + {{WIDTH{1'b0}}, 1'b1};
      OP_XOR:  alu_r = s1_q.ra ^ s1_q.rb;
      OP_AND:  alu_r = s1_q.ra & s1_q.rb;
      OP_OR:   alu_r = s1_q.ra | s1_q.rb;
      default: alu_r = s1_q.ra;
    endcase
  end

  always_comb begin
    o = s1_q.mode[0] ? (alu_r ^ acc_q[s1_q.sel]) : alu_r;
`ifdef LWC_ARX_PE_POSTROT_EN
    result_d = rotl(o, s1_q.rotr);
`else
    result_d = o;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (s2_load) begin
      result_q <= result_d;
      carry_q  <= alu_c;
    end
  end

  // Write shares the S2 load edge, so a following transaction on the same slot sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          acc_q <= '0;
    else if (bus.acc_clr)             acc_q <= '0;
    else if (s2_load && s1_q.mode[1]) acc_q[s1_q.sel] <= alu_r;
  end

  assign bus.out_valid = vld_q[2];
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
endmodule
